// File: rtl/axil_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// axil_master_arbiter_if
//   Bundles the two-requester command/response channels, the command outputs
//   that feed the AXI4-Lite master, and the B/R handshake signals snooped from
//   the bus.
//
//   modport master : arbiter view (drives rq_ready, rsp_*, m_*)
//   modport slave  : environment view (drives rq_*, snooped B/R signals)
//
//   Signal summary
//     rq_valid/rq_write   [1:0]         per-requester request and direction
//     rq_addr/rq_wdata    [2*WIDTH-1:0] requester i at [i*WIDTH +: WIDTH]
//     rq_wstrb            [2*WIDTH/8-1:0]
//     rq_ready/rsp_valid  [1:0]         one-cycle pulses to the granted requester
//     rsp_data/rsp_resp                 completion data and response code
//     m_wstart/m_rstart                 start strobes to the master
//     m_awaddr/m_araddr/m_wdata/m_wstrb command buses to the master
//     BVALID/BREADY/BRESP               write response handshake (snooped)
//     RVALID/RREADY/RRESP/RDATA         read data handshake (snooped)
// -----------------------------------------------------------------------------
interface axil_master_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [1:0]             rq_valid;
   logic [1:0]             rq_write;
   logic [2*WIDTH-1:0]     rq_addr;
   logic [2*WIDTH-1:0]     rq_wdata;
   logic [2*(WIDTH/8)-1:0] rq_wstrb;
   logic [1:0]             rq_ready;
   logic [1:0]             rsp_valid;
   logic [WIDTH-1:0]       rsp_data;
   logic [1:0]             rsp_resp;
   logic                   m_wstart;
   logic                   m_rstart;
   logic [WIDTH-1:0]       m_awaddr;
   logic [WIDTH-1:0]       m_araddr;
   logic [WIDTH-1:0]       m_wdata;
   logic [WIDTH/8-1:0]     m_wstrb;
   logic                   BVALID;
   logic                   BREADY;
   logic [1:0]             BRESP;
   logic                   RVALID;
   logic                   RREADY;
   logic [1:0]             RRESP;
   logic [WIDTH-1:0]       RDATA;

   modport master (
      input  rq_valid, rq_write, rq_addr, rq_wdata, rq_wstrb,
      input  BVALID, BREADY, BRESP, RVALID, RREADY, RRESP, RDATA,
      output rq_ready, rsp_valid, rsp_data, rsp_resp,
      output m_wstart, m_rstart, m_awaddr, m_araddr, m_wdata, m_wstrb
   );

   modport slave (
      output rq_valid, rq_write, rq_addr, rq_wdata, rq_wstrb,
      output BVALID, BREADY, BRESP, RVALID, RREADY, RRESP, RDATA,
      input  rq_ready, rsp_valid, rsp_data, rsp_resp,
      input  m_wstart, m_rstart, m_awaddr, m_araddr, m_wdata, m_wstrb
   );
endinterface

// File: rtl/axil_master_arbiter.sv
// -----------------------------------------------------------------------------
// axil_master_arbiter
//   Round-robin arbiter and sequencer for two local requesters in front of an
//   AXI4-Lite master. One single-beat read or write is in flight at a time:
//   IDLE (arbitrate) -> ISSUE (accept + start strobe) -> WAIT (watch B/R
//   handshake or watchdog) -> RESP (completion pulse) -> IDLE.
//
//   Parameters
//     WIDTH   : address/data width, strobe width is WIDTH/8
//     TIMEOUT : WAIT cycles before a transaction is forcibly ended (>= 2)
//
//   Ports
//     ACLK    : clock, rising edge
//     ARESETn : synchronous active-low reset
//     bus     : axil_master_arbiter_if.master (requester, master-command and
//               snooped handshake signals)
// -----------------------------------------------------------------------------
module axil_master_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   axil_master_arbiter_if.master bus
);

   localparam int SW = WIDTH / 8;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;

   logic             last_grant_r;
   logic             grant_r;
   logic             write_r;
   logic [TW-1:0]    tmo_cnt_r;

   logic [1:0]       rq_ready_r;
   logic [1:0]       rsp_valid_r;
   logic [1:0]       rsp_resp_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             m_wstart_r;
   logic             m_rstart_r;
   logic [WIDTH-1:0] m_awaddr_r;
   logic [WIDTH-1:0] m_araddr_r;
   logic [WIDTH-1:0] m_wdata_r;
   logic [SW-1:0]    m_wstrb_r;

   logic             req_any_s;
   logic             grant_s;
   logic             sel_write_s;
   logic [WIDTH-1:0] sel_addr_s;
   logic [WIDTH-1:0] sel_wdata_s;
   logic [SW-1:0]    sel_wstrb_s;
   logic             done_s;
   logic             expire_s;

   // Arbitration: a lone request wins outright, a tie goes to the requester
   // that was not granted last; the winner's command fields are selected.
   always_comb begin
      req_any_s = |bus.rq_valid;
      if (bus.rq_valid == 2'b11) begin
         grant_s = ~last_grant_r;
      end else begin
         grant_s = bus.rq_valid[1];
      end
      if (grant_s) begin
         sel_write_s = bus.rq_write[1];
         sel_addr_s  = bus.rq_addr[2*WIDTH-1:WIDTH];
         sel_wdata_s = bus.rq_wdata[2*WIDTH-1:WIDTH];
         sel_wstrb_s = bus.rq_wstrb[2*SW-1:SW];
      end else begin
         sel_write_s = bus.rq_write[0];
         sel_addr_s  = bus.rq_addr[WIDTH-1:0];
         sel_wdata_s = bus.rq_wdata[WIDTH-1:0];
         sel_wstrb_s = bus.rq_wstrb[SW-1:0];
      end
   end

   // Completion/expiry detection; handshakes are only meaningful in WAIT and
   // a completion on the final WAIT cycle suppresses the expiry.
   always_comb begin
      done_s   = 1'b0;
      expire_s = 1'b0;
      if (state_r == ST_WAIT) begin
         if (write_r) begin
            done_s = bus.BVALID && bus.BREADY;
         end else begin
            done_s = bus.RVALID && bus.RREADY;
         end
         expire_s = !done_s && (tmo_cnt_r == TMO_LAST);
      end else begin
         done_s   = 1'b0;
         expire_s = 1'b0;
      end
   end

   // Next-state logic of the transaction sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_any_s) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_next_s = ST_WAIT;
         ST_WAIT: begin
            if (done_s || expire_s) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and registered outputs. The grant, accept pulse, start strobe
   // and command buses load on the edge that enters ISSUE so that they are
   // all visible together during the ISSUE cycle.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         last_grant_r <= 1'b1;
         grant_r      <= 1'b0;
         write_r      <= 1'b0;
         tmo_cnt_r    <= '0;
         rq_ready_r   <= 2'b00;
         rsp_valid_r  <= 2'b00;
         rsp_resp_r   <= 2'b00;
         rsp_data_r   <= '0;
         m_wstart_r   <= 1'b0;
         m_rstart_r   <= 1'b0;
         m_awaddr_r   <= '0;
         m_araddr_r   <= '0;
         m_wdata_r    <= '0;
         m_wstrb_r    <= '0;
      end else begin
         rq_ready_r  <= 2'b00;
         rsp_valid_r <= 2'b00;
         m_wstart_r  <= 1'b0;
         m_rstart_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_any_s) begin
                  grant_r      <= grant_s;
                  last_grant_r <= grant_s;
                  write_r      <= sel_write_s;
                  rq_ready_r   <= grant_s ? 2'b10 : 2'b01;
                  m_wstart_r   <= sel_write_s;
                  m_rstart_r   <= !sel_write_s;
                  // Only the buses of the issued direction are refreshed.
                  if (sel_write_s) begin
                     m_awaddr_r <= sel_addr_s;
                     m_wdata_r  <= sel_wdata_s;
                     m_wstrb_r  <= sel_wstrb_s;
                  end else begin
                     m_araddr_r <= sel_addr_s;
                  end
               end
            end
            ST_ISSUE: begin
               tmo_cnt_r <= '0;
            end
            ST_WAIT: begin
               if (done_s) begin
                  rsp_valid_r <= grant_r ? 2'b10 : 2'b01;
                  if (write_r) begin
                     rsp_resp_r <= bus.BRESP;
                  end else begin
                     rsp_resp_r <= bus.RRESP;
                     rsp_data_r <= bus.RDATA;
                  end
               end else if (expire_s) begin
                  rsp_valid_r <= grant_r ? 2'b10 : 2'b01;
                  rsp_resp_r  <= 2'b11;
               end else if (tmo_cnt_r != TMO_LAST) begin
                  // Saturating count: expiry is taken before it could wrap.
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            ST_RESP: begin
               tmo_cnt_r <= '0;
            end
            default: begin
               tmo_cnt_r <= '0;
            end
         endcase
      end
   end

   assign bus.rq_ready  = rq_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_resp  = rsp_resp_r;
   assign bus.m_wstart  = m_wstart_r;
   assign bus.m_rstart  = m_rstart_r;
   assign bus.m_awaddr  = m_awaddr_r;
   assign bus.m_araddr  = m_araddr_r;
   assign bus.m_wdata   = m_wdata_r;
   assign bus.m_wstrb   = m_wstrb_r;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_master_arbiter
//   Directed stimulus against axil_master_arbiter (WIDTH=32, TIMEOUT=8).
//   A transaction-level model tracks grant order and issue/response edge
//   numbers and is compared with every DUT output on each falling edge;
//   literal expectations pin latencies, grant order and response codes.
// -----------------------------------------------------------------------------
module tb_axil_master_arbiter;

   localparam int WIDTH   = 32;
   localparam int SW      = WIDTH / 8;
   localparam int TIMEOUT = 8;

   logic ACLK = 1'b0;
   logic ARESETn;

   axil_master_arbiter_if #(.WIDTH(WIDTH)) bus ();

   axil_master_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int strobes = 0;
   int ready_edge = 0;
   int rsp_edge   = 0;
   int gq[$];

   // model state
   bit         mv = 1'b0;
   bit         m_busy, m_done, m_wr, m_g, m_last;
   int         m_issue;
   logic [1:0]       exp_rq_ready, exp_rsp_valid, exp_resp;
   logic             exp_ws, exp_rs;
   logic [WIDTH-1:0] exp_aw, exp_ar, exp_wd, exp_rd;
   logic [SW-1:0]    exp_strb;

   task automatic check_v(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic [159:0] dut_vec();
      return 160'({bus.rq_ready, bus.rsp_valid, bus.m_wstart, bus.m_rstart,
                   bus.m_awaddr, bus.m_araddr, bus.m_wdata, bus.m_wstrb,
                   bus.rsp_data, bus.rsp_resp});
   endfunction

   function automatic logic [159:0] exp_vec();
      return 160'({exp_rq_ready, exp_rsp_valid, exp_ws, exp_rs,
                   exp_aw, exp_ar, exp_wd, exp_strb, exp_rd, exp_resp});
   endfunction

   // Transaction model: a grant at edge N, WAIT handshakes counted at edges
   // N+2 .. N+1+TIMEOUT, response pulse after the ending edge, idle again one
   // edge later.
   task automatic model_step();
      int k;
      int gi;
      if (ARESETn !== 1'b1) begin
         mv = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_last = 1'b1;
         exp_rq_ready = 2'b00; exp_rsp_valid = 2'b00; exp_ws = 1'b0; exp_rs = 1'b0;
         exp_aw = '0; exp_ar = '0; exp_wd = '0; exp_strb = '0; exp_rd = '0; exp_resp = 2'b00;
      end else begin
         exp_rq_ready = 2'b00; exp_rsp_valid = 2'b00; exp_ws = 1'b0; exp_rs = 1'b0;
         if (!m_busy) begin
            if (bus.rq_valid != 2'b00) begin
               if (bus.rq_valid == 2'b11) m_g = ~m_last;
               else m_g = bus.rq_valid[1];
               gi = int'(m_g);
               m_wr = bus.rq_write[gi];
               m_busy = 1'b1; m_done = 1'b0; m_issue = cyc; m_last = m_g;
               exp_rq_ready[gi] = 1'b1;
               exp_ws = m_wr;
               exp_rs = !m_wr;
               if (m_wr) begin
                  exp_aw   = bus.rq_addr[gi*WIDTH +: WIDTH];
                  exp_wd   = bus.rq_wdata[gi*WIDTH +: WIDTH];
                  exp_strb = bus.rq_wstrb[gi*SW +: SW];
               end else begin
                  exp_ar = bus.rq_addr[gi*WIDTH +: WIDTH];
               end
            end
         end else if (!m_done) begin
            k  = cyc - m_issue - 1;
            gi = int'(m_g);
            if (k >= 1 && (m_wr ? (bus.BVALID && bus.BREADY) : (bus.RVALID && bus.RREADY))) begin
               m_done = 1'b1;
               exp_rsp_valid[gi] = 1'b1;
               exp_resp = m_wr ? bus.BRESP : bus.RRESP;
               if (!m_wr) exp_rd = bus.RDATA;
            end else if (k == TIMEOUT) begin
               m_done = 1'b1;
               exp_rsp_valid[gi] = 1'b1;
               exp_resp = 2'b11;
            end
         end else begin
            m_busy = 1'b0;
         end
      end
   endtask

   // One clock: model steps on the rising edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge ACLK);
      cyc++;
      model_step();
      @(negedge ACLK);
      if (mv) check_v("cycle", dut_vec(), exp_vec());
      if (bus.rq_ready != 2'b00) begin
         gq.push_back(int'(bus.rq_ready[1]));
         ready_edge = cyc;
      end
      if (bus.rsp_valid != 2'b00) rsp_edge = cyc;
      strobes += int'(bus.m_wstart) + int'(bus.m_rstart);
   endtask

   task automatic drive_req(input int r, input logic wr, input logic [WIDTH-1:0] addr,
                            input logic [WIDTH-1:0] wd, input logic [SW-1:0] strb);
      bus.rq_write[r] = wr;
      bus.rq_addr[r*WIDTH +: WIDTH]  = addr;
      bus.rq_wdata[r*WIDTH +: WIDTH] = wd;
      bus.rq_wstrb[r*SW +: SW]       = strb;
      bus.rq_valid[r] = 1'b1;
   endtask

   task automatic wait_ready(input int r, output int e);
      int n = 0;
      while (bus.rq_ready[r] !== 1'b1 && n < 40) begin tick(); n++; end
      check_i("ready_seen", int'(bus.rq_ready[r] === 1'b1), 1);
      e = cyc;
   endtask

   task automatic wait_rsp(input int r, output int e);
      int n = 0;
      while (bus.rsp_valid[r] !== 1'b1 && n < 60) begin tick(); n++; end
      check_i("rsp_seen", int'(bus.rsp_valid[r] === 1'b1), 1);
      e = cyc;
   endtask

   task automatic pulse_b(input logic [1:0] resp);
      bus.BVALID = 1'b1; bus.BREADY = 1'b1; bus.BRESP = resp;
      tick();
      bus.BVALID = 1'b0; bus.BREADY = 1'b0;
   endtask

   task automatic pulse_r(input logic [1:0] resp, input logic [WIDTH-1:0] data);
      bus.RVALID = 1'b1; bus.RREADY = 1'b1; bus.RRESP = resp; bus.RDATA = data;
      tick();
      bus.RVALID = 1'b0; bus.RREADY = 1'b0;
   endtask

   initial begin
      int e;
      int re;
      int req_e;
      int s0;
      bit was_wr;
      int n;

      ARESETn = 1'b0;
      bus.rq_valid = 2'b00; bus.rq_write = 2'b00; bus.rq_addr = '0;
      bus.rq_wdata = '0; bus.rq_wstrb = '0;
      bus.BVALID = 1'b0; bus.BREADY = 1'b0; bus.BRESP = 2'b00;
      bus.RVALID = 1'b0; bus.RREADY = 1'b0; bus.RRESP = 2'b00; bus.RDATA = '0;

      tick(); tick();
      check_v("rst_outputs", dut_vec(), 160'd0);
      ARESETn = 1'b1;
      tick();

      // single write from requester 0
      drive_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
      req_e = cyc + 1;
      wait_ready(0, e);
      bus.rq_valid[0] = 1'b0;
      check_i("w_ready_lat", e, req_e);
      check_v("w_strobes", 160'({bus.m_wstart, bus.m_rstart}), 160'(2'b10));
      check_v("w_awaddr", 160'(bus.m_awaddr), 160'(32'h0000_0010));
      check_v("w_wdata", 160'(bus.m_wdata), 160'(32'hDEAD_BEEF));
      tick(); tick();
      pulse_b(2'b00);
      check_v("w_rsp_valid", 160'(bus.rsp_valid), 160'(2'b01));
      check_v("w_rsp_resp", 160'(bus.rsp_resp), 160'(2'b00));
      tick();

      // read from requester 1, with a stray R handshake during ISSUE
      drive_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
      wait_ready(1, e);
      bus.rq_valid[1] = 1'b0;
      check_v("r_strobes", 160'({bus.m_wstart, bus.m_rstart}), 160'(2'b01));
      check_v("r_araddr", 160'(bus.m_araddr), 160'(32'h0000_0020));
      check_v("r_awaddr_kept", 160'(bus.m_awaddr), 160'(32'h0000_0010));
      pulse_r(2'b10, 32'hBAD0_BAD0);
      check_v("r_issue_hs_ignored", 160'(bus.rsp_valid), 160'(2'b00));
      tick();
      pulse_r(2'b00, 32'h1234_5678);
      check_v("r_rsp_valid", 160'(bus.rsp_valid), 160'(2'b10));
      check_v("r_rsp_data", 160'(bus.rsp_data), 160'(32'h1234_5678));
      tick();

      // watchdog expiry on a read that never completes
      drive_req(1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
      wait_ready(1, e);
      bus.rq_valid[1] = 1'b0;
      wait_rsp(1, re);
      check_i("tmo_latency", re - e, 9);
      check_v("tmo_resp", 160'(bus.rsp_resp), 160'(2'b11));
      check_v("tmo_data_kept", 160'(bus.rsp_data), 160'(32'h1234_5678));
      tick();

      // next transaction completes normally
      drive_req(0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'h3);
      wait_ready(0, e);
      bus.rq_valid[0] = 1'b0;
      check_v("n_wstrb", 160'(bus.m_wstrb), 160'(4'h3));
      tick(); tick();
      pulse_b(2'b01);
      check_v("n_rsp", 160'({bus.rsp_valid, bus.rsp_resp}), 160'(4'b01_01));
      check_v("n_data_kept", 160'(bus.rsp_data), 160'(32'h1234_5678));
      tick();

      // completion on the very last WAIT cycle beats expiry
      drive_req(1, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
      wait_ready(1, e);
      bus.rq_valid[1] = 1'b0;
      repeat (TIMEOUT) tick();
      pulse_r(2'b10, 32'hCAFE_F00D);
      check_i("sim_latency", cyc - e, 9);
      check_v("sim_rsp", 160'({bus.rsp_valid, bus.rsp_resp}), 160'(4'b10_10));
      check_v("sim_data", 160'(bus.rsp_data), 160'(32'hCAFE_F00D));
      tick();

      // reset in the middle of a write's WAIT phase
      drive_req(0, 1'b1, 32'h0000_0060, 32'h1111_2222, 4'hF);
      wait_ready(0, e);
      bus.rq_valid[0] = 1'b0;
      tick(); tick();
      drive_req(0, 1'b1, 32'h0000_0070, 32'h3333_4444, 4'hF);
      drive_req(1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
      ARESETn = 1'b0;
      tick();
      check_v("mid_rst_outputs", dut_vec(), 160'd0);
      ARESETn = 1'b1;

      // continuous contention from reset: grants alternate starting with 0
      gq.delete();
      s0 = strobes;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (bus.rq_ready === 2'b00 && n < 40) begin tick(); n++; end
         check_i("cont_ready_seen", int'(bus.rq_ready != 2'b00), 1);
         was_wr = bus.m_wstart;
         if (i == 3) bus.rq_valid = 2'b00;
         tick(); tick();
         if (was_wr) pulse_b(2'b00);
         else pulse_r(2'b00, 32'h0000_1000 + 32'(i));
         check_i("cont_rsp_seen", int'(bus.rsp_valid != 2'b00), 1);
      end
      check_i("cont_grants", gq.size(), 4);
      if (gq.size() == 4) begin
         check_i("grant0", gq[0], 0);
         check_i("grant1", gq[1], 1);
         check_i("grant2", gq[2], 0);
         check_i("grant3", gq[3], 1);
      end
      check_i("cont_strobes", strobes - s0, 4);
      check_i("last_rsp_after_ready", int'(rsp_edge > ready_edge), 1);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
